hilo_mdu: RTL

HILO_MDU -- requirements
Module: hilo_mdu

---
 rtl/hilo_mdu_pkg.sv | 17 +
 rtl/hilo_div_iter.sv | 57 +++++
 rtl/hilo_mdu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: opcodes, FSM states and default width.
package hilo_mdu_pkg;

  localparam int HILO_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/hilo_div_iter.sv
// Unsigned restoring divider, one quotient bit per i_step; operands are magnitudes,
// sign handling lives in the parent.
module hilo_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  // Partial remainder never exceeds 2*divisor, so WIDTH+1 bits hold the trial subtraction.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
      r_cnt <= '0;
    end else if (i_step) begin
      if (!w_diff[WIDTH]) begin
        r_rem <= w_diff[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_last      = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit with a single-cycle commit window and read bypass.
// Optional MADD/MSUB accumulate support is enabled by defining HILO_MDU_MADD_EN.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             exception_flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_read_val,
  output logic [WIDTH-1:0] lo_read_val,
  output logic [1:0]       dbg_state
);

  state_t r_state, w_next;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic             r_we_hi, r_we_lo, r_dbz, r_neg_q, r_neg_r;

  logic             w_accept, w_is_mul, w_is_div, w_signed_div, w_we_hi, w_we_lo;
  logic             w_div_last, w_op_is_div;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_quo, w_rem;
  logic [WIDTH-1:0] w_div_hi, w_div_lo, w_pend_hi, w_pend_lo;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u, w_mul_res;

  assign w_accept = (r_state == IDLE) && start && !exception_flush;
`ifdef HILO_MDU_MADD_EN
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
`else
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign w_is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign w_signed_div = (op == OP_DIV);
  assign w_we_hi      = w_is_mul || w_is_div || (op == OP_MTHI);
  assign w_we_lo      = w_is_mul || w_is_div || (op == OP_MTLO);
  assign w_mag_a      = (w_signed_div && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_mag_b      = (w_signed_div && src_b[WIDTH-1]) ? -src_b : src_b;

  hilo_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept && w_is_div),
    .i_step      (r_state == DIV),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_last      (w_div_last)
  );

  // MIN/-1 needs no special case: |MIN| fits unsigned and both signs cancel.
  assign w_op_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_div_lo    = r_dbz ? '1  : (r_neg_q ? -w_quo : w_quo);
  assign w_div_hi    = r_dbz ? r_a : (r_neg_r ? -w_rem : w_rem);
  assign w_pend_hi   = w_op_is_div ? w_div_hi : r_pend_hi;
  assign w_pend_lo   = w_op_is_div ? w_div_lo : r_pend_lo;

  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  always_comb begin
    w_mul_res = w_prod_s;
    case (r_op)
      OP_MULTU: w_mul_res = w_prod_u;
`ifdef HILO_MDU_MADD_EN
      OP_MADD:  w_mul_res = {r_hi, r_lo} + w_prod_s;
      OP_MSUB:  w_mul_res = {r_hi, r_lo} - w_prod_s;
`endif
      default:  w_mul_res = w_prod_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    div_by_zero = (r_state == DONE) && r_dbz;
    case (r_state)
      IDLE: if (w_accept) w_next = w_is_mul ? MUL : (w_is_div ? DIV : DONE);
      MUL:  w_next = exception_flush ? IDLE : DONE;
      DIV:  if (exception_flush) w_next = IDLE;
            else if (w_div_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_we_hi   <= 1'b0;
      r_we_lo   <= 1'b0;
      r_dbz     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= op;
        r_a       <= src_a;
        r_b       <= src_b;
        r_pend_hi <= src_a;
        r_pend_lo <= src_a;
        r_we_hi   <= w_we_hi;
        r_we_lo   <= w_we_lo;
        r_dbz     <= w_is_div && (src_b == '0);
        r_neg_q   <= w_signed_div && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        r_neg_r   <= w_signed_div && src_a[WIDTH-1];
      end
      if (r_state == MUL) begin
        r_pend_hi <= w_mul_res[2*WIDTH-1:WIDTH];
        r_pend_lo <= w_mul_res[WIDTH-1:0];
      end
      if ((r_state == DONE) && !exception_flush) begin
        if (r_we_hi) r_hi <= w_pend_hi;
        if (r_we_lo) r_lo <= w_pend_lo;
      end
    end
  end

  // Bypass stays on during a flushed DONE so the pending value is visible that cycle.
  assign hi_read_val = ((r_state == DONE) && r_we_hi) ? w_pend_hi : r_hi;
  assign lo_read_val = ((r_state == DONE) && r_we_lo) ? w_pend_lo : r_lo;
  assign dbg_state   = r_state;

endmodule
